uart_rx: RTL
============

# uart_rx

Serial receiver for the 8N1 UART link, the receive half paired with the existing transmitter at the same `CLKS_PER_BIT`. It synchronises the `rx` pin, samples each bit mid-cell, and delivers bytes through a one-deep holding register with a full/read handshake. Framing and overrun errors are flagged. It sits between the board UART pin and the CPU's memory-mapped UART peripheral.

## Interface
- `CLKS_PER_BIT`, 1000, clock cycles per serial bit; must be ≥ 4.
- `INVERT`, 0, when 1 the `rx` pin is logically inverted before synchronisation; idle line reads as 0 on the pin.

- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `rx`  in  1  serial input; asynchronous to `clk`.
- `re`  in  1  read strobe; consumes the held byte.
- `dout`  out  8  received byte, valid while `full` = 1.
- `full`  out  1  holding register contains an unread byte.
- `frame_err`  out  1  last frame had stop bit = 0; sticky until next good frame or reset.
- `overrun`  out  1  a byte completed while `full` = 1; sticky until `re` or reset.

## Operation
- Input path: `rx` XOR `INVERT` → 2-flop synchroniser → `rx_s`. Line idle is `rx_s` = 1.
- Internal counter is 16 bits. Bit index is 3 bits. Shift register is 8 bits, LSB first: `shift <= {bit, shift[7:1]}`.
- `HALF` = `CLKS_PER_BIT`/2, using integer division.
- FSM states:
  - IDLE: count = 0, index = 0. Go to START_BIT when `rx_s` = 0.
  - START_BIT: count increments. When count = `HALF`−1, sample the line. If the sample is 0, go to DATA_BITS with count = 0. If the sample is 1, treat it as a glitch and return to IDLE with no flags changed.
  - DATA_BITS: count increments. When count = `CLKS_PER_BIT`−1, sample, shift the bit in, set count = 0, and increment index. After index 7, go to STOP_BIT.
  - STOP_BIT: when count = `CLKS_PER_BIT`−1, sample and go to IDLE. The receiver re-arms at mid-stop-bit.
    - Sample 1: good frame; `frame_err` <= 0; deliver the byte.
    - Sample 0: `frame_err` <= 1; the byte is discarded; `full`, `dout` and `overrun` are unchanged.
- Byte delivery for a good frame:
  - `full` = 0, or `re` = 1 in the same cycle: `dout` <= shift, `full` <= 1, `overrun` unchanged.
  - `full` = 1 and `re` = 0: the new byte is dropped, `dout` keeps the old byte, `overrun` <= 1.
- `re` with `full` = 1 and no delivery that cycle: `full` <= 0, `overrun` <= 0.
- `re` with `full` = 0: no effect. `dout` holds its last value.
- Any unused state encoding returns to IDLE.
- Reset mid-frame: asynchronous return to IDLE. A partial byte is lost; no flag is set.

## Timing
- Reset values:
  - `dout` = 0x00, `full` = 0, `frame_err` = 0, `overrun` = 0.
  - State = IDLE. Synchroniser flops = 1, so the line reads idle.
- Synchroniser latency is 2 cycles from pin to `rx_s`.
- Start detection: START_BIT is entered 1 cycle after `rx_s` falls.
- Data bit n (n = 0..7) is sampled `HALF` + (n+1)·`CLKS_PER_BIT` cycles after START_BIT entry.
- `full` rises in the cycle after the stop-bit sample. This is about 9.5·`CLKS_PER_BIT` + 3 cycles after the pin falling edge.
- `full` falls in the cycle after `re` is sampled high.
- Back-to-back frames with no idle gap are received without loss, provided `re` is serviced within 1 frame time.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined:
  - A 3-bit history of `rx_s` is kept.
  - Every sample point (start, data, stop) uses the majority of the last 3 `rx_s` values, including the current one.
  - A single-cycle glitch cannot corrupt a bit or trigger a false start.
- Undefined: each sample point uses the single current `rx_s` value. No history register is built.

## Test plan
- **Good byte:** `CLKS_PER_BIT`=16, drive 0xA5 as 8N1 → `dout`=0xA5, `full`=1 about 155 cycles after the start edge, `frame_err`=0. Pulse `re` → `full`=0 the next cycle.
- **Overrun:** send 0x3C then 0xC3 with no `re` → `dout`=0x3C, `full`=1, `overrun`=1. Then `re` → `full`=0, `overrun`=0.
- **Simultaneous read and delivery:** with `full`=1 holding 0x11, assert `re` in the exact cycle 0x22 completes → `dout`=0x22, `full`=1, `overrun`=0.
- **Framing error:** send 0x55 with stop bit 0 → `frame_err`=1, `full` unchanged. Then send a good 0x0F → `frame_err`=0, `dout`=0x0F.
- **False start:** a 3-cycle low pulse on an idle line → no `full`, no flags, FSM back in IDLE. With `UART_RX_MAJORITY_EN`, a 1-cycle low inside data bit 3 of 0xFF still yields 0xFF.
- **Reset and inversion:** assert `rst_n` low mid-frame → all outputs are at reset values immediately, and the next frame is received correctly. With `INVERT`=1, an inverted 0x81 yields `dout`=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// 8N1 UART receiver. The rx pin is optionally inverted and then passed
// through a 2-flop synchroniser. Each bit is sampled in the middle of its
// cell. Received bytes go into a one-deep holding register that is read
// with a full/re handshake. Framing errors and overruns are flagged.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (must be >= 4)
//   INVERT        1 = rx pin is logically inverted (idle line reads 0 on the pin)
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial input, asynchronous to clk
//   re         in   read strobe, consumes the held byte
//   dout       out  received byte, valid while full = 1
//   full       out  holding register contains an unread byte
//   frame_err  out  last frame had a zero stop bit (sticky until next good frame)
//   overrun    out  a byte completed while full = 1 (sticky until re)
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every sample point takes a 2-of-3
//                        majority over the last three synchronised values.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1000,
  parameter bit          INVERT       = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       re,
  output logic [7:0] dout,
  output logic       full,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;

  logic        sync1_q;
  logic        sync2_q;
  logic        rxIn;
  logic        rxS;
  logic        sampleBit;

  logic [2:0]  state_q,    state_d;
  logic [15:0] count_q,    count_d;
  logic [2:0]  index_q,    index_d;
  logic [7:0]  shift_q,    shift_d;
  logic [7:0]  dout_q,     dout_d;
  logic        full_q,     full_d;
  logic        frameErr_q, frameErr_d;
  logic        overrun_q,  overrun_d;

  logic        stopSample;
  logic        goodFrame;
  logic        badFrame;
  logic        deliver;

  assign rxIn = rx ^ INVERT;
  assign rxS  = sync2_q;

  // Synchroniser resets to 1 so the line reads idle straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxIn;
      sync2_q <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Two previous synchronised values; together with the current one they
  // form the 3-sample window for the majority vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxS};
    end
  end

  assign sampleBit = (rxS & hist_q[0]) | (rxS & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sampleBit = rxS;
`endif

  // Frame sequencer. The count runs from 0 in each state; START samples at
  // the half-bit point, so every later sample lands mid-cell.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    shift_d    = shift_q;
    stopSample = 1'b0;
    case (state_q)
      ST_IDLE: begin
        count_d = 16'd0;
        index_d = 3'd0;
        if (!rxS) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (count_q == HALF_M1) begin
          count_d = 16'd0;
          // A high sample here means the falling edge was a glitch.
          state_d = sampleBit ? ST_IDLE : ST_DATA;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (count_q == FULL_M1) begin
          count_d = 16'd0;
          shift_d = {sampleBit, shift_q[7:1]};
          index_d = index_q + 3'd1;
          if (index_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      ST_STOP: begin
        // Re-arm at mid-stop-bit so back-to-back frames are not missed.
        if (count_q == FULL_M1) begin
          count_d    = 16'd0;
          stopSample = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          count_d = count_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 16'd0;
        index_d = 3'd0;
      end
    endcase
  end

  assign goodFrame = stopSample & sampleBit;
  assign badFrame  = stopSample & ~sampleBit;
  // A read in the same cycle frees the holding register for the new byte.
  assign deliver   = goodFrame & (~full_q | re);

  // Holding register and status flags. A bad frame only touches frame_err;
  // the byte it carried is discarded.
  always_comb begin
    dout_d     = dout_q;
    full_d     = full_q;
    frameErr_d = frameErr_q;
    overrun_d  = overrun_q;
    if (goodFrame) begin
      frameErr_d = 1'b0;
    end
    if (badFrame) begin
      frameErr_d = 1'b1;
    end
    if (deliver) begin
      dout_d = shift_q;
      full_d = 1'b1;
    end else if (goodFrame) begin
      overrun_d = 1'b1;
    end else if (re && full_q) begin
      full_d    = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= 16'd0;
      index_q    <= 3'd0;
      shift_q    <= 8'h00;
      dout_q     <= 8'h00;
      full_q     <= 1'b0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      shift_q    <= shift_d;
      dout_q     <= dout_d;
      full_q     <= full_d;
      frameErr_q <= frameErr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign dout      = dout_q;
  assign full      = full_q;
  assign frame_err = frameErr_q;
  assign overrun   = overrun_q;

endmodule
